// File: rtl/branch_pkg.sv
// branch_pkg: shared op encoding, FSM state type and sign-extend-and-shift helper for the branch unit
package branch_pkg;
  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J} br_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_e;
  function automatic logic [63:0] sext_shl(input logic [63:0] imm, input int imm_w, input int shift);
    logic [63:0] m;
    m = ~64'd0 << imm_w;
    return (imm[6'(imm_w - 1)] ? (imm | m) : (imm & ~m)) << shift;
  endfunction
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: combinational target = in_pc4 + (sext(in_imm) << SHIFT), wraps mod 2^XLEN; ports in_pc4, in_imm -> target
module branch_target_adder
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16,
  parameter int SHIFT = 2
) (
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [IMM_W-1:0] in_imm,
  output logic [XLEN-1:0]  target
);
  assign target = in_pc4 + XLEN'(sext_shl(64'(in_imm), IMM_W, SHIFT));
endmodule

// File: rtl/branch_target_unit.sv
// branch_target_unit: EX-stage branch resolve with redirect handshake and counted flush; ports clk, rst (async high), in_valid/in_op/in_pc4/in_imm/in_a/in_b, stall -> in_ready, redirect, target_pc, flush, busy, taken_cnt/resolved_cnt (live only with BRANCH_STATS_EN)
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int IMM_W        = 16,
  parameter int SHIFT        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic             stall,
  output logic             in_ready,
  output logic             redirect,
  output logic [XLEN-1:0]  target_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt
);
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  br_op_e op;
  state_e state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic [XLEN-1:0] target, target_d, target_q;
  logic redirect_d, redirect_q, flush_d, flush_q, taken, accept;
  branch_target_adder #(.XLEN(XLEN), .IMM_W(IMM_W), .SHIFT(SHIFT)) u_adder (
    .in_pc4(in_pc4),
    .in_imm(in_imm),
    .target(target)
  );
  assign op        = br_op_e'(in_op);
  assign taken     = op == BR_J || (op == BR_BEQ && in_a == in_b) || (op == BR_BNE && in_a != in_b);
  assign in_ready  = state_q == ST_IDLE && !stall;
  assign accept    = in_valid && in_ready;
  assign redirect  = redirect_q;
  assign flush     = flush_q;
  assign busy      = state_q != ST_IDLE;
  assign target_pc = redirect_q ? target_q : '0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = accept && op != BR_NONE ? target : target_q;
    if (state_q == ST_IDLE) begin
      state_d = accept && taken ? ST_REDIRECT : ST_IDLE;
    end else if (state_q == ST_REDIRECT) begin
      state_d = stall ? ST_REDIRECT : ST_FLUSH;
      cnt_d   = stall ? cnt_q : CNT_INIT;
    end else begin
      state_d = cnt_q == 4'd0 ? ST_IDLE : ST_FLUSH;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end
    redirect_d = state_d == ST_REDIRECT;
    flush_d    = state_d == ST_FLUSH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
    end
  end
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_d, taken_cnt_q, resolved_cnt_d, resolved_cnt_q;
  always_comb begin
    resolved_cnt_d = resolved_cnt_q + CNT_W'(accept && op != BR_NONE);
    taken_cnt_d    = taken_cnt_q + CNT_W'(accept && taken);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q    <= '0;
      resolved_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end
  assign taken_cnt    = taken_cnt_q;
  assign resolved_cnt = resolved_cnt_q;
`else
  assign taken_cnt    = '0;
  assign resolved_cnt = '0;
`endif
endmodule
